// File: rtl/result_byte_scanner.sv
// Shows a 32-bit SoC result word one byte at a time on eight LEDs,
// restarting the scan from byte 0 whenever the result word changes.
module result_byte_scanner #(
   parameter int unsigned DWELL_CYCLES = 50000000,
   parameter bit          REPEAT       = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] result_in,
   output logic [7:0]  leds,
   output logic [1:0]  byte_idx,
   output logic        busy,
   output logic [7:0]  update_count
);

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_t;

   localparam logic [31:0] LAST_COUNT = 32'(DWELL_CYCLES - 1);

   state_t      state;
   state_t      nextState;
   logic [31:0] shadow;
   logic [31:0] hold;
   logic [31:0] nextHold;
   logic [31:0] dwellCount;
   logic [31:0] nextCount;
   logic [1:0]  nextIdx;
   logic [7:0]  nextLeds;
   logic        nextBusy;
   logic [7:0]  nextUpdate;
   logic        change;
   logic        dwellEnd;

   assign change   = (result_in != shadow);
   assign dwellEnd = (dwellCount == LAST_COUNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // A change event always wins over the dwell timer, so a new word that
   // lands on a dwell-end edge restarts at byte 0 without an IDLE cycle.
   always_comb begin
      nextState = state;
      nextHold  = hold;
      nextCount = dwellCount;
      nextIdx   = byte_idx;
      if (change) begin
         nextHold  = result_in;
         nextCount = 32'd0;
         nextIdx   = 2'd0;
         nextState = SHOW;
      end else if (state == SHOW) begin
         if (dwellEnd) begin
            nextCount = 32'd0;
            if (byte_idx == 2'd3) begin
               nextIdx   = 2'd0;
               nextState = REPEAT ? SHOW : IDLE;
            end else begin
               nextIdx = byte_idx + 2'd1;
            end
         end else begin
            nextCount = dwellCount + 32'd1;
         end
      end
   end

   // Outputs are computed from the next-cycle values so that leds carry the
   // new byte exactly one cycle after result_in changes.
   always_comb begin
      nextBusy   = (nextState == SHOW);
      nextUpdate = update_count + {7'd0, change};
      nextLeds   = nextHold[7:0];
      if (nextState == SHOW) begin
         case (nextIdx)
            2'd0:    nextLeds = nextHold[7:0];
            2'd1:    nextLeds = nextHold[15:8];
            2'd2:    nextLeds = nextHold[23:16];
            default: nextLeds = nextHold[31:24];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow       <= 32'd0;
         hold         <= 32'd0;
         dwellCount   <= 32'd0;
         byte_idx     <= 2'd0;
         leds         <= 8'd0;
         busy         <= 1'b0;
         update_count <= 8'd0;
      end else begin
         shadow       <= result_in;
         hold         <= nextHold;
         dwellCount   <= nextCount;
         byte_idx     <= nextIdx;
         leds         <= nextLeds;
         busy         <= nextBusy;
         update_count <= nextUpdate;
      end
   end

endmodule

// File: tb/tb_result_byte_scanner.sv
// Drives three scanner configurations from one result word and compares them
// against a model that derives the shown byte from time elapsed since a change.
module tb_result_byte_scanner;

   logic        clk;
   logic        reset;
   logic [31:0] result_in;

   logic [2:0][7:0] ledsAll;
   logic [2:0][1:0] idxAll;
   logic [2:0]      busyAll;
   logic [2:0][7:0] countAll;

   int dwellTab [3] = '{4, 4, 1};
   bit repTab   [3] = '{1'b0, 1'b1, 1'b0};

   int checks = 0;
   int errors = 0;

   logic [31:0] mHold;
   logic [31:0] mPrev;
   logic [7:0]  mCount;
   bit          mStarted;
   longint      mElapsed;

   result_byte_scanner #(.DWELL_CYCLES(4), .REPEAT(1'b0)) dutOnce (
      .clk(clk), .reset(reset), .result_in(result_in),
      .leds(ledsAll[0]), .byte_idx(idxAll[0]), .busy(busyAll[0]),
      .update_count(countAll[0]));

   result_byte_scanner #(.DWELL_CYCLES(4), .REPEAT(1'b1)) dutLoop (
      .clk(clk), .reset(reset), .result_in(result_in),
      .leds(ledsAll[1]), .byte_idx(idxAll[1]), .busy(busyAll[1]),
      .update_count(countAll[1]));

   result_byte_scanner #(.DWELL_CYCLES(1), .REPEAT(1'b0)) dutFast (
      .clk(clk), .reset(reset), .result_in(result_in),
      .leds(ledsAll[2]), .byte_idx(idxAll[2]), .busy(busyAll[2]),
      .update_count(countAll[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      mHold    = 32'd0;
      mPrev    = 32'd0;
      mCount   = 8'd0;
      mStarted = 1'b0;
      mElapsed = 0;
   endtask

   task automatic modelEdge(input logic [31:0] v);
      if (v != mPrev) begin
         mHold    = v;
         mElapsed = 0;
         mStarted = 1'b1;
         mCount   = mCount + 8'd1;
      end else if (mStarted) begin
         mElapsed = mElapsed + 1;
      end
      mPrev = v;
   endtask

   task automatic checkOutput(input string tag);
      longint     b;
      logic [7:0] eLeds;
      logic [1:0] eIdx;
      logic       eBusy;
      for (int k = 0; k < 3; k++) begin
         eIdx  = 2'd0;
         eBusy = 1'b0;
         if (mStarted) begin
            b = mElapsed / dwellTab[k];
            if (repTab[k]) begin
               eIdx  = 2'(b % 4);
               eBusy = 1'b1;
            end else if (b < 4) begin
               eIdx  = 2'(b);
               eBusy = 1'b1;
            end
         end
         eLeds = 8'(mHold >> (8 * eIdx));
         checks += 4;
         assert (ledsAll[k] === eLeds) else begin
            errors++;
            $error("FAIL %s dut%0d leds observed=%h expected=%h", tag, k, ledsAll[k], eLeds);
         end
         assert (idxAll[k] === eIdx) else begin
            errors++;
            $error("FAIL %s dut%0d byte_idx observed=%0d expected=%0d", tag, k, idxAll[k], eIdx);
         end
         assert (busyAll[k] === eBusy) else begin
            errors++;
            $error("FAIL %s dut%0d busy observed=%b expected=%b", tag, k, busyAll[k], eBusy);
         end
         assert (countAll[k] === mCount) else begin
            errors++;
            $error("FAIL %s dut%0d update_count observed=%0d expected=%0d", tag, k, countAll[k], mCount);
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Called at a negedge: holds v for n cycles, checking after every edge.
   task automatic applyStimulus(input logic [31:0] v, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         result_in = v;
         @(posedge clk);
         modelEdge(v);
         @(negedge clk);
         checkOutput(tag);
      end
   endtask

   initial begin
      logic [31:0] v;
      reset     = 1'b1;
      result_in = 32'd0;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset");
      reset = 1'b0;

      applyStimulus(32'd0, 20, "idleZero");

      applyStimulus(32'hA1B2C3D4, 1, "scanStart");
      checkValue("scanStartLeds", ledsAll[0], 8'hD4);
      checkValue("scanStartBusy", {7'd0, busyAll[0]}, 8'd1);
      applyStimulus(32'hA1B2C3D4, 19, "scanOnce");
      checkValue("scanEndLeds", ledsAll[0], 8'hD4);
      checkValue("scanEndBusy", {7'd0, busyAll[0]}, 8'd0);
      checkValue("scanEndCount", countAll[0], 8'd1);

      applyStimulus(32'h11223344, 20, "repeatScan");
      checkValue("repeatBusy", {7'd0, busyAll[1]}, 8'd1);

      applyStimulus(32'hCAFEBABE, 9, "preMidChange");
      checkValue("midByte2", {6'd0, idxAll[0]}, 8'd2);
      applyStimulus(32'h000000FF, 1, "midChange");
      checkValue("midChangeLeds", ledsAll[0], 8'hFF);
      checkValue("midChangeIdx", {6'd0, idxAll[0]}, 8'd0);
      applyStimulus(32'h000000FF, 6, "afterMidChange");

      applyStimulus(32'h5A5A0F0F, 16, "preDwellEnd");
      applyStimulus(32'h12345678, 1, "dwellEndChange");
      checkValue("dwellEndBusy", {7'd0, busyAll[0]}, 8'd1);
      checkValue("dwellEndLeds", ledsAll[0], 8'h78);
      applyStimulus(32'h12345678, 5, "afterDwellEnd");

      applyStimulus(32'h87654321, 6, "preReset");
      #2 reset = 1'b1;
      #1 modelReset();
      checkOutput("asyncReset");
      @(negedge clk);
      checkOutput("heldReset");
      reset = 1'b0;
      applyStimulus(32'h87654321, 20, "afterReset");

      for (int s = 0; s < 40; s++) begin
         v = $urandom;
         if ($urandom_range(0, 4) == 0) v = 32'd0;
         applyStimulus(v, int'($urandom_range(1, 20)), "random");
      end

      @(negedge clk);
      reset = 1'b1;
      #1 modelReset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         v = 32'(i + 1) * 32'h9E3779B1;
         applyStimulus(v, 1, "wrapRun");
      end
      checkValue("wrapCount", countAll[2], 8'd0);
      applyStimulus(v, 6, "wrapSettle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
